// File: rtl/hex_ascii_tx.sv
// ============================================================================
// Module   : hex_ascii_tx
// Brief    : Serializes a binary word as uppercase ASCII hex over a
//            valid/ready byte stream, MSB nibble first, optional CR LF.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hex_ascii_tx #(
   parameter int WORD_NIBBLES = 8,
   parameter bit SEND_CRLF    = 1'b1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [4*WORD_NIBBLES-1:0] word_in,
   input  logic                      start,
   output logic                      busy,
   output logic [7:0]                byte_out,
   output logic                      byte_valid,
   input  logic                      byte_ready,
   output logic                      done
);

   localparam int C_WORD_W = 4 * WORD_NIBBLES;
   localparam int C_CNT_W  = (WORD_NIBBLES > 1) ? $clog2(WORD_NIBBLES) : 1;
   localparam logic [C_CNT_W-1:0] C_LAST_CNT = C_CNT_W'(WORD_NIBBLES - 1);
   localparam logic [7:0] C_ASCII_CR = 8'h0D;
   localparam logic [7:0] C_ASCII_LF = 8'h0A;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DIGIT = 2'd1,
      S_CR    = 2'd2,
      S_LF    = 2'd3
   } state_t;

   state_t               r_state;
   logic [C_WORD_W-1:0]  r_shift;
   logic [C_CNT_W-1:0]   r_cnt;
   logic [7:0]           r_byte;
   logic                 r_valid;
   logic                 r_busy;
   logic                 r_done;

   logic                 w_xfer;
   logic [C_WORD_W-1:0]  w_shift_next;

   function automatic logic [7:0] nib2ascii(input logic [3:0] nib);
      if (nib < 4'd10) begin
         return 8'h30 + {4'h0, nib};
      end
      return 8'h37 + {4'h0, nib};
   endfunction

   assign w_xfer       = r_valid & byte_ready;
   assign w_shift_next = r_shift << 4;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_shift <= '0;
         r_cnt   <= '0;
         r_byte  <= 8'h00;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_shift <= word_in;
                  r_byte  <= nib2ascii(word_in[C_WORD_W-1 -: 4]);
                  r_valid <= 1'b1;
                  r_busy  <= 1'b1;
                  r_cnt   <= '0;
                  r_state <= S_DIGIT;
               end
            end
            S_DIGIT: begin
               if (w_xfer) begin
                  if (r_cnt != C_LAST_CNT) begin
                     // The next digit is the top nibble after this shift.
                     r_shift <= w_shift_next;
                     r_byte  <= nib2ascii(w_shift_next[C_WORD_W-1 -: 4]);
                     r_cnt   <= r_cnt + 1'b1;
                  end else if (SEND_CRLF) begin
                     r_byte  <= C_ASCII_CR;
                     r_state <= S_CR;
                  end else begin
                     r_valid <= 1'b0;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                     r_state <= S_IDLE;
                  end
               end
            end
            S_CR: begin
               if (w_xfer) begin
                  r_byte  <= C_ASCII_LF;
                  r_state <= S_LF;
               end
            end
            S_LF: begin
               if (w_xfer) begin
                  r_valid <= 1'b0;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_valid <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign busy       = r_busy;
   assign byte_out   = r_byte;
   assign byte_valid = r_valid;
   assign done       = r_done;

endmodule

`default_nettype wire
